// File: rtl/micro8_cpu.sv
// micro8_cpu: 8-bit multi-cycle microprocessor.
//   - Four general registers (A, B, C, D), accumulator, PC, IR, operand latch T,
//     zero and carry flags.
//   - Shares one synchronous 256x8 RAM for program and data. Read data is
//     valid in the cycle after the address was presented.
//   - Internal state is exported on test outputs for a system-level bench.
//   - Optional feature, macro CPU_HALT_EN: when defined, opcode F parks the
//     core in HALT until reset. When undefined, opcode F behaves as NOP.
module micro8_cpu #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ram_out,
  output logic [7:0] ram_data,
  output logic [7:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] test_state,
  output logic [7:0] test_A,
  output logic [7:0] test_B,
  output logic [7:0] test_C,
  output logic [7:0] test_D,
  output logic [7:0] test_Acc,
  output logic [7:0] pc_out,
  output logic [7:0] ir_out,
  output logic       zero,
  output logic       carry
);

  // Control sequencer states. The encodings are visible on test_state.
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_LATCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_OPERAND = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  // Instruction opcodes, taken from IR[7:4].
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LD  = 4'h2,
    OP_ST  = 4'h3,
    OP_MOV = 4'h4,
    OP_ADD = 4'h5,
    OP_SUB = 4'h6,
    OP_AND = 4'h7,
    OP_OR  = 4'h8,
    OP_XOR = 4'h9,
    OP_NOT = 4'hA,
    OP_MVA = 4'hB,
    OP_JMP = 4'hC,
    OP_JZ  = 4'hD,
    OP_JC  = 4'hE,
    OP_HLT = 4'hF
  } op_t;

  // Architectural state.
  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic [7:0] r_t;
  logic [7:0] r_acc;
  logic [7:0] r_gpr [4];
  logic       r_zero;
  logic       r_carry;

  // Decode and datapath wires.
  state_t     w_next_state;
  op_t        w_op;
  logic [1:0] w_rx_sel;
  logic [1:0] w_ry_sel;
  logic [7:0] w_rx;
  logic [7:0] w_ry;
  logic       w_two_byte;
  logic       w_is_jump;
  logic       w_jump_taken;
  logic [8:0] w_sum9;
  logic [7:0] w_alu_res;
  logic       w_alu_carry;
  logic       w_alu_en;
  logic [7:0] w_pc_inc;

  assign w_op     = op_t'(r_ir[7:4]);
  assign w_rx_sel = r_ir[3:2];
  assign w_ry_sel = r_ir[1:0];
  assign w_rx     = r_gpr[w_rx_sel];
  assign w_ry     = r_gpr[w_ry_sel];
  // 8-bit add wraps naturally from 8'hFF to 8'h00.
  assign w_pc_inc = r_pc + 8'd1;

  // Decode instruction length and branch class.
  always_comb begin
    w_two_byte = 1'b0;
    w_is_jump  = 1'b0;
    case (w_op)
      OP_LDI, OP_LD, OP_ST: w_two_byte = 1'b1;
      OP_JMP, OP_JZ, OP_JC: begin
        w_two_byte = 1'b1;
        w_is_jump  = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch condition, evaluated against the flags left by earlier ALU ops.
  always_comb begin
    w_jump_taken = 1'b0;
    case (w_op)
      OP_JMP:  w_jump_taken = 1'b1;
      OP_JZ:   w_jump_taken = r_zero;
      OP_JC:   w_jump_taken = r_carry;
      default: w_jump_taken = 1'b0;
    endcase
  end

  // ALU: result, carry/borrow, and whether this opcode updates the flags.
  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_sum9      = {1'b0, w_rx} + {1'b0, w_ry};
    w_alu_res   = 8'h00;
    w_alu_carry = 1'b0;
    w_alu_en    = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_alu_res   = w_sum9[7:0];
        w_alu_carry = w_sum9[8];
        w_alu_en    = 1'b1;
      end
      OP_SUB: begin
        // The result wraps modulo 256. Carry reports a borrow.
        w_alu_res   = w_rx - w_ry;
        w_alu_carry = (w_rx < w_ry);
        w_alu_en    = 1'b1;
      end
      OP_AND: begin
        w_alu_res = w_rx & w_ry;
        w_alu_en  = 1'b1;
      end
      OP_OR: begin
        w_alu_res = w_rx | w_ry;
        w_alu_en  = 1'b1;
      end
      OP_XOR: begin
        w_alu_res = w_rx ^ w_ry;
        w_alu_en  = 1'b1;
      end
      OP_NOT: begin
        w_alu_res = ~w_rx;
        w_alu_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer state register.
  // NOTE: clocked state uses non-blocking assignments, so every flop samples
  // its pre-edge inputs regardless of the order of the statements.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state logic for the sequencer.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_LATCH;
      S_LATCH: w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_two_byte) begin
          w_next_state = S_OPERAND;
        end else if (w_op == OP_HLT) begin
`ifdef CPU_HALT_EN
          w_next_state = S_HALT;
`else
          w_next_state = S_FETCH;
`endif
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_OPERAND: w_next_state = (w_op == OP_LD || w_op == OP_ST) ? S_MEM : S_FETCH;
      S_MEM:     w_next_state = (w_op == OP_LD) ? S_WB : S_FETCH;
      S_WB:      w_next_state = S_FETCH;
      S_HALT:    w_next_state = S_HALT;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // RAM interface. The address is PC except in MEM, where the operand latch
  // points at the data location. The write strobe is gated by rst_n, so a
  // reset that lands on an in-flight ST never writes memory.
  always_comb begin
    ram_addr = r_pc;
    ram_data = w_rx;
    ram_we   = 1'b0;
    if (r_state == S_MEM) begin
      ram_addr = r_t;
      ram_we   = rst_n && (w_op == OP_ST);
    end
  end

  // Datapath registers: PC, IR, operand latch, register file, accumulator, flags.
  // NOTE: the four-entry register file is made of plain flops and is cleared
  // on reset along with the rest of the architectural state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_ir    <= 8'h00;
      r_t     <= 8'h00;
      r_acc   <= 8'h00;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      for (int i = 0; i < 4; i++) r_gpr[i] <= 8'h00;
    end else begin
      case (r_state)
        S_LATCH: begin
          r_ir <= ram_out;
          r_pc <= w_pc_inc;
        end
        S_EXEC: begin
          if (w_alu_en) begin
            r_acc   <= w_alu_res;
            r_zero  <= (w_alu_res == 8'h00);
            r_carry <= w_alu_carry;
          end
          if (w_op == OP_MOV) r_gpr[w_rx_sel] <= w_ry;
          if (w_op == OP_MVA) r_gpr[w_rx_sel] <= r_acc;
        end
        S_OPERAND: begin
          r_t  <= ram_out;
          r_pc <= (w_is_jump && w_jump_taken) ? ram_out : w_pc_inc;
          if (w_op == OP_LDI) r_gpr[w_rx_sel] <= ram_out;
        end
        S_WB: r_gpr[w_rx_sel] <= ram_out;
        default: ;
      endcase
    end
  end

  // Test visibility.
  assign test_state = {5'b00000, r_state};
  assign test_A     = r_gpr[0];
  assign test_B     = r_gpr[1];
  assign test_C     = r_gpr[2];
  assign test_D     = r_gpr[3];
  assign test_Acc   = r_acc;
  assign pc_out     = r_pc;
  assign ir_out     = r_ir;
  assign zero       = r_zero;
  assign carry      = r_carry;

endmodule

// File: tb/tb_micro8_cpu.sv
// tb_micro8_cpu: runs a short program on micro8_cpu with a behavioural
// 256x8 synchronous RAM. While the program is assembled into RAM, the bench
// pushes the architectural state it expects after each instruction into a
// scoreboard queue. When the core returns to FETCH, the bench pops one entry
// and compares the registers, flags, PC and the instruction's cycle count.
module tb_micro8_cpu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ram_out;
  logic [7:0] ram_data;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] test_state;
  logic [7:0] test_A, test_B, test_C, test_D, test_Acc;
  logic [7:0] pc_out, ir_out;
  logic       zero, carry;

  micro8_cpu #(.RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ram_out    (ram_out),
    .ram_data   (ram_data),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .test_state (test_state),
    .test_A     (test_A),
    .test_B     (test_B),
    .test_C     (test_C),
    .test_D     (test_D),
    .test_Acc   (test_Acc),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .zero       (zero),
    .carry      (carry)
  );

  always #5 clk = ~clk;

  // Companion RAM: synchronous read, data valid in the following cycle.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_out <= mem[ram_addr];
  end

  typedef struct {
    logic [7:0] pc, a, b, c, d, acc;
    logic       z, cy;
    int         cycles;
  } exp_t;

  exp_t       sb[$];
  exp_t       m;
  logic [7:0] wp;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Program assembly helpers. Each one writes the instruction bytes and
  // records the hand-computed state expected after the instruction completes.
  task automatic put(input logic [7:0] b);
    mem[wp] = b;
    wp++;
  endtask

  task automatic retire(input int cyc);
    m.pc     = wp;
    m.cycles = cyc;
    sb.push_back(m);
  endtask

  task automatic set_reg(input logic [1:0] r, input logic [7:0] v);
    case (r)
      2'd0: m.a = v;
      2'd1: m.b = v;
      2'd2: m.c = v;
      default: m.d = v;
    endcase
  endtask

  task automatic i_ldi(input logic [1:0] rx, input logic [7:0] imm);
    put({4'h1, rx, 2'b00});
    put(imm);
    set_reg(rx, imm);
    retire(4);
  endtask

  task automatic i_alu(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry,
                       input logic [7:0] acc, input logic z, input logic cy);
    put({op, rx, ry});
    m.acc = acc;
    m.z   = z;
    m.cy  = cy;
    retire(3);
  endtask

  task automatic i_st(input logic [1:0] rx, input logic [7:0] a);
    put({4'h3, rx, 2'b00});
    put(a);
    retire(5);
  endtask

  task automatic i_ld(input logic [1:0] rx, input logic [7:0] a, input logic [7:0] val);
    put({4'h2, rx, 2'b00});
    put(a);
    set_reg(rx, val);
    retire(6);
  endtask

  // MOV (op 4) and MVA (op B): register write, flags untouched.
  task automatic i_move(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry,
                        input logic [7:0] val);
    put({op, rx, ry});
    set_reg(rx, val);
    retire(3);
  endtask

  task automatic i_nop(input logic [7:0] opbyte);
    put(opbyte);
    retire(3);
  endtask

  task automatic i_jump(input logic [3:0] op, input logic [7:0] target, input logic taken);
    put({op, 4'h0});
    put(target);
    if (taken) wp = target;
    retire(4);
  endtask

  exp_t       e;
  logic [7:0] prev_state;
  int         cyc, last_ret, we_cnt, idx;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    m = '{pc: 8'h00, a: 8'h00, b: 8'h00, c: 8'h00, d: 8'h00, acc: 8'h00,
          z: 1'b0, cy: 1'b0, cycles: 0};
    wp = 8'h00;

    // Program with expected post-instruction state.
    i_ldi(2'd0, 8'hF0);                          // 00 LDI A,F0
    i_ldi(2'd1, 8'h20);                          // 02 LDI B,20
    i_alu(4'h5, 2'd0, 2'd1, 8'h10, 1'b0, 1'b1);  // 04 ADD A,B
    i_alu(4'h6, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0);  // 05 SUB A,A
    i_jump(4'hD, 8'h40, 1'b1);                   // 06 JZ 40 (taken)
    i_ldi(2'd2, 8'h5A);                          // 40 LDI C,5A
    i_st(2'd2, 8'h80);                           // 42 ST C,[80]
    i_ld(2'd3, 8'h80, 8'h5A);                    // 44 LD D,[80]
    i_alu(4'h5, 2'd2, 2'd3, 8'hB4, 1'b0, 1'b0);  // 46 ADD C,D
    i_jump(4'hD, 8'h40, 1'b0);                   // 47 JZ 40 (not taken)
    i_ldi(2'd0, 8'hCC);                          // 49 LDI A,CC
    i_ldi(2'd1, 8'hAA);                          // 4B LDI B,AA
    i_alu(4'h5, 2'd0, 2'd1, 8'h76, 1'b0, 1'b1);  // 4D ADD A,B (sets carry)
    i_alu(4'h7, 2'd0, 2'd1, 8'h88, 1'b0, 1'b0);  // 4E AND A,B (clears carry)
    i_alu(4'h8, 2'd0, 2'd1, 8'hEE, 1'b0, 1'b0);  // 4F OR  A,B
    i_alu(4'h9, 2'd0, 2'd1, 8'h66, 1'b0, 1'b0);  // 50 XOR A,B
    i_alu(4'h6, 2'd1, 2'd0, 8'hDE, 1'b0, 1'b1);  // 51 SUB B,A (borrow)
    i_alu(4'hA, 2'd0, 2'd0, 8'h33, 1'b0, 1'b0);  // 52 NOT A (clears carry)
    i_move(4'hB, 2'd1, 2'd0, 8'h33);             // 53 MVA B
    i_move(4'h4, 2'd2, 2'd1, 8'h33);             // 54 MOV C,B
    i_nop(8'h00);                                // 55 NOP
    i_jump(4'hE, 8'h60, 1'b0);                   // 56 JC 60 (not taken)
    i_alu(4'h6, 2'd3, 2'd0, 8'h8E, 1'b0, 1'b1);  // 58 SUB D,A (borrow)
    i_jump(4'hE, 8'h60, 1'b1);                   // 59 JC 60 (taken)
`ifdef CPU_HALT_EN
    put(8'hF0);                                  // 60 HLT (never retires)
`else
    i_nop(8'hF0);                                // 60 HLT acts as NOP
    i_jump(4'hC, 8'h00, 1'b1);                   // 61 JMP 00
    i_ldi(2'd0, 8'hF0);                          // 00 LDI A,F0 again
`endif

    // Reset held for two edges.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", test_state, 8'h00);
    check("rst_pc",    pc_out,     8'h00);
    check("rst_ir",    ir_out,     8'h00);
    check("rst_A",     test_A,     8'h00);
    check("rst_B",     test_B,     8'h00);
    check("rst_C",     test_C,     8'h00);
    check("rst_D",     test_D,     8'h00);
    check("rst_acc",   test_Acc,   8'h00);
    check("rst_zero",  zero,       1'b0);
    check("rst_carry", carry,      1'b0);
    check("rst_we",    ram_we,     1'b0);
    rst_n = 1'b1;

    // Execute, popping one scoreboard entry per completed instruction.
    prev_state = 8'h00;
    cyc        = 0;
    last_ret   = 0;
    we_cnt     = 0;
    idx        = 0;
    while (sb.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (ram_we) begin
        we_cnt++;
        check("we_state", test_state, 8'h04);
        check("we_addr",  ram_addr,   8'h80);
        check("we_data",  ram_data,   8'h5A);
      end
      if (test_state == 8'h00 && prev_state != 8'h00) begin
        e = sb.pop_front();
        check($sformatf("i%0d_pc",  idx), pc_out,   e.pc);
        check($sformatf("i%0d_A",   idx), test_A,   e.a);
        check($sformatf("i%0d_B",   idx), test_B,   e.b);
        check($sformatf("i%0d_C",   idx), test_C,   e.c);
        check($sformatf("i%0d_D",   idx), test_D,   e.d);
        check($sformatf("i%0d_acc", idx), test_Acc, e.acc);
        check($sformatf("i%0d_z",   idx), zero,     e.z);
        check($sformatf("i%0d_c",   idx), carry,    e.cy);
        check($sformatf("i%0d_cyc", idx), cyc - last_ret, e.cycles);
        last_ret = cyc;
        idx++;
      end
      prev_state = test_state;
    end
    check("sb_drained", sb.size(), 0);
    check("we_pulses",  we_cnt,    1);
    check("mem80",      mem[8'h80], 8'h5A);

`ifdef CPU_HALT_EN
    // HLT parks the core with PC just past the HLT byte.
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("halt_state", test_state, 8'h06);
      check("halt_pc",    pc_out,     8'h61);
      repeat (5) @(negedge clk);
    end
`endif

    // A one-edge reset pulse returns the core to its initial state.
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_state", test_state, 8'h00);
    check("rst2_pc",    pc_out,     8'h00);
    check("rst2_A",     test_A,     8'h00);
    check("rst2_we",    ram_we,     1'b0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
